wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the MangoMIPS32 core: consumes the registered MEM/WB bundle and commits it to architectural state. It aligns and extends load data, selects the final GPR result, and owns the 32×32 general-purpose register file, the HI/LO pair and the LLbit. It also provides forwarded read ports to the decode and execute stages.

## Interface
- No parameters. Widths come from the shared `defines.v` macros: `AddrBus`/`DataBus` = 32, `ByteWEn` = 4, `RegAddr` = 5, `DWord` = 64, `ALUOp` = core opcode width.
- Clocking: one clock; reset is synchronous and active-high.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- wb_aluop  in  ALUOp  committed operation
- wb_alures  in  32  ALU/address result
- wb_mulres  in  32  low product for MUL
- wb_m_vaddr  in  32  load virtual address; only [1:0] used
- wb_m_rdata  in  32  raw aligned memory word
- wb_wreg  in  4  byte write enables (bit i = byte i)
- wb_wraddr  in  5  destination GPR
- wb_hilo_wen  in  1  HI/LO write enable
- wb_hilo  in  64  {HI, LO} write value
- wb_llb_wen  in  1  LLbit write enable
- wb_llbit  in  1  LLbit write value
- llb_clr  in  1  clear LLbit (exception/ERET)
- r1_addr, r2_addr  in  5  GPR read addresses
- r1_data, r2_data  out  32  GPR read data (forwarded)
- hilo_o  out  64  {HI, LO} (forwarded)
- llbit_o  out  1  current LLbit (forwarded)

## Operation
- **Load extraction.** Let k = wb_m_vaddr[1:0] (little-endian).
  - LB/LBU: byte k, sign-/zero-extended.
  - LH/LHU: halfword k[1], sign-/zero-extended.
  - LW/LL: the full word.
  - LWL: value = rdata << 8·(3−k); byte mask = bytes 3 down to 3−k.
  - LWR: value = rdata >> 8·k; byte mask = bytes 3−k down to 0.
  - For all other ops the mask is 4'b1111.
- **Result mux.**
  - Loads: the extracted value.
  - SC: {31'b0, wb_llbit}.
  - MUL: wb_mulres.
  - All other ops: wb_alures.
- **Effective enable.** eff_wen = wb_wreg & mask.
- **GPR write.** At posedge clk, each byte i with eff_wen[i]=1 and wb_wraddr≠0 takes result byte i. Other bytes keep their old value. GPR0 is never written and always reads 0.
- **GPR read.** Combinational.
  - If raddr = 0, output 0.
  - Otherwise, each byte i is the current-cycle write byte when wraddr = raddr and eff_wen[i]=1; else the stored byte.
- **HI/LO.** Written with wb_hilo when wb_hilo_wen=1. hilo_o = wb_hilo_wen ? wb_hilo : stored.
- **LLbit.**
  - Priority: llb_clr (next = 0) > wb_llb_wen (next = wb_llbit) > hold.
  - llbit_o shows the next value combinationally, using the same priority.
- **Reset.** Clears all GPRs, HI, LO and LLbit to 0.
  - Read outputs show stored values of 0, except where forwarding applies.
  - With rst=1 all writes are suppressed, and forwarding still follows the inputs.

## Timing
- Writes commit on the posedge after the inputs are presented.
- A value is visible through the read ports in the same cycle via forwarding, and from storage on the next cycle.
- Read paths are zero-latency combinational.
- There is no stall input: the upstream pipeline register inserts bubbles as wreg=0, hilo_wen=0 and llb_wen=0.
- A bubble must leave all state unchanged.
- Simultaneous events:
  - A GPR write and a read of the same register in the same cycle: the read returns the new value byte-wise.
  - llb_clr and llb_wen together: clear wins.
  - SC and llb_clr together: rt gets the incoming wb_llbit (the SC outcome decided in MEM), and LLbit becomes 0.
- Reset mid-stream: the first cycle after rst deasserts sees all-zero state; any write presented while rst=1 is lost.

## Test plan
- **Reset then read.** Assert rst for 2 cycles, then read all 32 GPRs and HI/LO → all 0; llbit_o = 0.
- **Sign extension.**
  - Setup: rdata = 0x80FF7F01, k = 1, wreg = 4'b1111, wraddr = 5.
  - LB → GPR5 = 0x0000007F; LBU → 0x0000007F. With k = 3: LB → 0xFFFFFF80.
  - LH at k = 2 → 0xFFFF80FF; LHU → 0x000080FF.
- **LWL/LWR merge.**
  - Setup: GPR7 = 0x11223344, rdata = 0xAABBCCDD.
  - LWL at k = 1 → 0xCCDD3344.
  - Starting again from 0x11223344, LWR at k = 2 → 0x1122AABB.
- **Forwarding and GPR0.**
  - Write 0xDEADBEEF to r9 while r1_addr = 9 → r1_data = 0xDEADBEEF in the same cycle.
  - Write to r0 → r0 still reads 0.
  - Partial write with wreg = 4'b0011 → only the low half changes.
- **HI/LO.** hilo_wen with 0x0123456789ABCDEF → hilo_o shows the new value in the same cycle, then holds with wen = 0.
- **LLbit and SC.**
  - LL sets llbit = 1.
  - SC with wb_llbit = 1 → rt = 1.
  - llb_clr together with llb_wen = 1 → llbit_o = 0, and 0 is stored on the next cycle.

Source files
------------

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage : writeback stage of the MangoMIPS32 core.
//
// Takes the registered MEM/WB bundle and commits it to architectural state:
// aligns and extends load data, picks the final GPR result, and owns the
// 32x32 general-purpose register file, the HI/LO pair and the LLbit. The
// read ports forward the value being written this cycle, so decode and
// execute see a result in the same cycle it is presented here.
//
// Ports
//   clk          in   1   core clock
//   rst          in   1   synchronous active-high reset
//   wb_aluop     in   6   committed operation (encodings below)
//   wb_alures    in  32   ALU/address result
//   wb_mulres    in  32   low product for MUL
//   wb_m_vaddr   in  32   load virtual address (only [1:0] matter)
//   wb_m_rdata   in  32   raw aligned memory word
//   wb_wreg      in   4   byte write enables (bit i = byte i)
//   wb_wraddr    in   5   destination GPR
//   wb_hilo_wen  in   1   HI/LO write enable
//   wb_hilo      in  64   {HI, LO} write value
//   wb_llb_wen   in   1   LLbit write enable
//   wb_llbit     in   1   LLbit write value / SC outcome
//   llb_clr      in   1   clear LLbit (exception/ERET)
//   r1_addr      in   5   GPR read address, port 1
//   r2_addr      in   5   GPR read address, port 2
//   r1_data      out 32   GPR read data, port 1 (forwarded)
//   r2_data      out 32   GPR read data, port 2 (forwarded)
//   hilo_o       out 64   {HI, LO} (forwarded)
//   llbit_o      out  1   current LLbit (forwarded)
// -----------------------------------------------------------------------------
module wb_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  wb_aluop,
   input  logic [31:0] wb_alures,
   input  logic [31:0] wb_mulres,
   input  logic [31:0] wb_m_vaddr,
   input  logic [31:0] wb_m_rdata,
   input  logic [3:0]  wb_wreg,
   input  logic [4:0]  wb_wraddr,
   input  logic        wb_hilo_wen,
   input  logic [63:0] wb_hilo,
   input  logic        wb_llb_wen,
   input  logic        wb_llbit,
   input  logic        llb_clr,
   input  logic [4:0]  r1_addr,
   input  logic [4:0]  r2_addr,
   output logic [31:0] r1_data,
   output logic [31:0] r2_data,
   output logic [63:0] hilo_o,
   output logic        llbit_o
);

   // Core opcode encodings for the operations this stage distinguishes.
   localparam logic [5:0] OP_NOP = 6'h00;
   localparam logic [5:0] OP_ADD = 6'h01;
   localparam logic [5:0] OP_MUL = 6'h02;
   localparam logic [5:0] OP_LB  = 6'h08;
   localparam logic [5:0] OP_LBU = 6'h09;
   localparam logic [5:0] OP_LH  = 6'h0A;
   localparam logic [5:0] OP_LHU = 6'h0B;
   localparam logic [5:0] OP_LW  = 6'h0C;
   localparam logic [5:0] OP_LWL = 6'h0D;
   localparam logic [5:0] OP_LWR = 6'h0E;
   localparam logic [5:0] OP_LL  = 6'h0F;
   localparam logic [5:0] OP_SC  = 6'h10;

   // Only the byte offset of the load address is meaningful here.
   logic unused_vaddr;
   assign unused_vaddr = ^wb_m_vaddr[31:2];

   // -------------------------------------------------------------------------
   // Load extraction
   // -------------------------------------------------------------------------
   logic [1:0]  k;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [1:0]  lwl_sh;
   logic [31:0] lwl_val;
   logic [31:0] lwr_val;
   logic [3:0]  lwl_mask;
   logic [3:0]  lwr_mask;

   assign k       = wb_m_vaddr[1:0];
   assign ld_byte = wb_m_rdata[{k, 3'b000} +: 8];
   assign ld_half = k[1] ? wb_m_rdata[31:16] : wb_m_rdata[15:0];

   // LWL moves the addressed byte up to byte 3 and fills bytes 3..3-k;
   // LWR moves it down to byte 0 and fills bytes 3-k..0.
   assign lwl_sh   = 2'd3 - k;
   assign lwl_val  = wb_m_rdata << {lwl_sh, 3'b000};
   assign lwr_val  = wb_m_rdata >> {k, 3'b000};
   assign lwl_mask = 4'(4'b1111 << lwl_sh);
   assign lwr_mask = 4'b1111 >> k;

   // -------------------------------------------------------------------------
   // Result mux and effective byte enables
   // -------------------------------------------------------------------------
   logic [31:0] result;
   logic [3:0]  mask;
   logic [3:0]  eff_wen;

   always_comb begin
      result = wb_alures;
      mask   = 4'b1111;
      case (wb_aluop)
         OP_LB:         result = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:        result = {24'b0, ld_byte};
         OP_LH:         result = {{16{ld_half[15]}}, ld_half};
         OP_LHU:        result = {16'b0, ld_half};
         OP_LW, OP_LL:  result = wb_m_rdata;
         OP_LWL: begin
            result = lwl_val;
            mask   = lwl_mask;
         end
         OP_LWR: begin
            result = lwr_val;
            mask   = lwr_mask;
         end
         // The SC outcome was decided in MEM and arrives on wb_llbit.
         OP_SC:         result = {31'b0, wb_llbit};
         OP_MUL:        result = wb_mulres;
         OP_NOP, OP_ADD: result = wb_alures;
         default:       result = wb_alures;
      endcase
   end

   assign eff_wen = wb_wreg & mask;

   // -------------------------------------------------------------------------
   // General-purpose register file
   // -------------------------------------------------------------------------
   logic [31:0] gpr_reg [0:31];
   logic [31:0] wr_sel;

   // One-hot destination decode; entry 0 is never selected so GPR0 stays 0.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_wr_sel
         if (gi == 0) begin : g_zero
            assign wr_sel[gi] = 1'b0;
         end else begin : g_dec
            assign wr_sel[gi] = (wb_wraddr == 5'(gi));
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            gpr_reg[i] <= '0;
         end
      end else begin
         for (int i = 1; i < 32; i++) begin
            for (int b = 0; b < 4; b++) begin
               if (wr_sel[i] && eff_wen[b]) begin
                  gpr_reg[i][8*b +: 8] <= result[8*b +: 8];
               end
            end
         end
      end
   end

   // Byte-wise forwarding: a byte being written this cycle to the addressed
   // register overrides the stored byte. Forwarding ignores rst on purpose.
   function automatic logic [31:0] read_port(input logic [4:0] addr);
      logic [31:0] data;
      data = '0;
      if (addr != 5'd0) begin
         data = gpr_reg[addr];
         for (int b = 0; b < 4; b++) begin
            if ((wb_wraddr == addr) && eff_wen[b]) begin
               data[8*b +: 8] = result[8*b +: 8];
            end
         end
      end
      return data;
   endfunction

   assign r1_data = read_port(r1_addr);
   assign r2_data = read_port(r2_addr);

   // -------------------------------------------------------------------------
   // HI/LO
   // -------------------------------------------------------------------------
   logic [63:0] hilo_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         hilo_reg <= '0;
      end else if (wb_hilo_wen) begin
         hilo_reg <= wb_hilo;
      end
   end

   assign hilo_o = wb_hilo_wen ? wb_hilo : hilo_reg;

   // -------------------------------------------------------------------------
   // LLbit: clear beats write beats hold; the output shows the next value.
   // -------------------------------------------------------------------------
   logic llbit_reg;
   logic llbit_next;

   always_comb begin
      llbit_next = llbit_reg;
      if (llb_clr) begin
         llbit_next = 1'b0;
      end else if (wb_llb_wen) begin
         llbit_next = wb_llbit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         llbit_reg <= 1'b0;
      end else begin
         llbit_reg <= llbit_next;
      end
   end

   assign llbit_o = llbit_next;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

   localparam logic [5:0] OP_NOP = 6'h00;
   localparam logic [5:0] OP_ADD = 6'h01;
   localparam logic [5:0] OP_MUL = 6'h02;
   localparam logic [5:0] OP_LB  = 6'h08;
   localparam logic [5:0] OP_LBU = 6'h09;
   localparam logic [5:0] OP_LH  = 6'h0A;
   localparam logic [5:0] OP_LHU = 6'h0B;
   localparam logic [5:0] OP_LWL = 6'h0D;
   localparam logic [5:0] OP_LWR = 6'h0E;
   localparam logic [5:0] OP_LL  = 6'h0F;
   localparam logic [5:0] OP_SC  = 6'h10;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  wb_aluop;
   logic [31:0] wb_alures;
   logic [31:0] wb_mulres;
   logic [31:0] wb_m_vaddr;
   logic [31:0] wb_m_rdata;
   logic [3:0]  wb_wreg;
   logic [4:0]  wb_wraddr;
   logic        wb_hilo_wen;
   logic [63:0] wb_hilo;
   logic        wb_llb_wen;
   logic        wb_llbit;
   logic        llb_clr;
   logic [4:0]  r1_addr;
   logic [4:0]  r2_addr;
   logic [31:0] r1_data;
   logic [31:0] r2_data;
   logic [63:0] hilo_o;
   logic        llbit_o;

   int n_cmp = 0;
   int n_bad = 0;
   logic [63:0] exp_q [$];

   always #5 clk = ~clk;

   wb_stage dut (
      .clk         (clk),
      .rst         (rst),
      .wb_aluop    (wb_aluop),
      .wb_alures   (wb_alures),
      .wb_mulres   (wb_mulres),
      .wb_m_vaddr  (wb_m_vaddr),
      .wb_m_rdata  (wb_m_rdata),
      .wb_wreg     (wb_wreg),
      .wb_wraddr   (wb_wraddr),
      .wb_hilo_wen (wb_hilo_wen),
      .wb_hilo     (wb_hilo),
      .wb_llb_wen  (wb_llb_wen),
      .wb_llbit    (wb_llbit),
      .llb_clr     (llb_clr),
      .r1_addr     (r1_addr),
      .r2_addr     (r2_addr),
      .r1_data     (r1_data),
      .r2_data     (r2_data),
      .hilo_o      (hilo_o),
      .llbit_o     (llbit_o)
   );

   task automatic push(input logic [63:0] v);
      exp_q.push_back(v);
   endtask

   task automatic check(input string tag, input logic [63:0] obs);
      logic [63:0] exp;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $error("FAIL %s: observed %h, no expected value queued", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
         $display("check %-14s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bubble();
      wb_aluop    = OP_NOP;
      wb_wreg     = 4'b0000;
      wb_hilo_wen = 1'b0;
      wb_llb_wen  = 1'b0;
      llb_clr     = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one GPR-writing op, check both read ports in the same cycle
   // (forwarded) and again from storage on the following cycle.
   task automatic wr_check(input string tag, input logic [5:0] op,
                           input logic [31:0] alu, input logic [31:0] mul,
                           input logic [1:0] off, input logic [31:0] rdata,
                           input logic [3:0] wreg, input logic [4:0] waddr,
                           input logic [31:0] exp);
      wb_aluop   = op;
      wb_alures  = alu;
      wb_mulres  = mul;
      wb_m_vaddr = {30'h1000_0000, off};
      wb_m_rdata = rdata;
      wb_wreg    = wreg;
      wb_wraddr  = waddr;
      r1_addr    = waddr;
      r2_addr    = waddr;
      #1;
      push({32'b0, exp}); check({tag, "_f1"}, {32'b0, r1_data});
      push({32'b0, exp}); check({tag, "_f2"}, {32'b0, r2_data});
      step();
      bubble();
      #1;
      push({32'b0, exp}); check({tag, "_s1"}, {32'b0, r1_data});
      push({32'b0, exp}); check({tag, "_s2"}, {32'b0, r2_data});
   endtask

   initial begin
      rst = 1'b1;
      bubble();
      wb_alures = '0; wb_mulres = '0; wb_m_vaddr = '0; wb_m_rdata = '0;
      wb_wraddr = '0; wb_hilo = '0; wb_llbit = 1'b0;
      r1_addr = '0; r2_addr = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;

      // Reset state: every GPR, HI/LO and LLbit read zero.
      for (int i = 0; i < 32; i++) begin
         r1_addr = 5'(i);
         r2_addr = 5'(31 - i);
         #1;
         push(64'd0); check($sformatf("rst_r1_%0d", i), {32'b0, r1_data});
         push(64'd0); check($sformatf("rst_r2_%0d", i), {32'b0, r2_data});
      end
      push(64'd0); check("rst_hilo", hilo_o);
      push(64'd0); check("rst_llbit", {63'b0, llbit_o});

      // Byte/halfword extraction and extension.
      step();
      wr_check("lb_k1",  OP_LB,  32'h0, 32'h0, 2'd1, 32'h80FF7F01, 4'hF, 5'd5, 32'h0000007F);
      wr_check("lbu_k1", OP_LBU, 32'h0, 32'h0, 2'd1, 32'h80FF7F01, 4'hF, 5'd5, 32'h0000007F);
      wr_check("lb_k3",  OP_LB,  32'h0, 32'h0, 2'd3, 32'h80FF7F01, 4'hF, 5'd5, 32'hFFFFFF80);
      wr_check("lbu_k3", OP_LBU, 32'h0, 32'h0, 2'd3, 32'h80FF7F01, 4'hF, 5'd5, 32'h00000080);
      wr_check("lh_k2",  OP_LH,  32'h0, 32'h0, 2'd2, 32'h80FF7F01, 4'hF, 5'd5, 32'hFFFF80FF);
      wr_check("lhu_k2", OP_LHU, 32'h0, 32'h0, 2'd2, 32'h80FF7F01, 4'hF, 5'd5, 32'h000080FF);
      wr_check("lh_k0",  OP_LH,  32'h0, 32'h0, 2'd0, 32'h80FF7F01, 4'hF, 5'd5, 32'h00007F01);

      // LWL/LWR merge with the old register contents.
      wr_check("set_r7a", OP_ADD, 32'h11223344, 32'h0, 2'd0, 32'h0, 4'hF, 5'd7, 32'h11223344);
      wr_check("lwl_k1",  OP_LWL, 32'h0, 32'h0, 2'd1, 32'hAABBCCDD, 4'hF, 5'd7, 32'hCCDD3344);
      wr_check("set_r7b", OP_ADD, 32'h11223344, 32'h0, 2'd0, 32'h0, 4'hF, 5'd7, 32'h11223344);
      wr_check("lwr_k2",  OP_LWR, 32'h0, 32'h0, 2'd2, 32'hAABBCCDD, 4'hF, 5'd7, 32'h1122AABB);
      wr_check("lwl_k0",  OP_LWL, 32'h0, 32'h0, 2'd0, 32'h99887766, 4'hF, 5'd7, 32'h6622AABB);
      wr_check("lwr_k3",  OP_LWR, 32'h0, 32'h0, 2'd3, 32'h55000000, 4'hF, 5'd7, 32'h6622AA55);

      // Forwarding, GPR0, partial writes, MUL.
      wr_check("fwd_r9",  OP_ADD, 32'hDEADBEEF, 32'h0, 2'd0, 32'h0, 4'hF, 5'd9, 32'hDEADBEEF);
      wr_check("r0_wr",   OP_ADD, 32'hFFFFFFFF, 32'h0, 2'd0, 32'h0, 4'hF, 5'd0, 32'h00000000);
      wr_check("part_r9", OP_ADD, 32'h12345678, 32'h0, 2'd0, 32'h0, 4'b0011, 5'd9, 32'hDEAD5678);
      wr_check("mul_r10", OP_MUL, 32'h0BADF00D, 32'hCAFEF00D, 2'd0, 32'h0, 4'hF, 5'd10, 32'hCAFEF00D);

      // A bubble (wreg=0) addressed at r9 changes nothing.
      wr_check("bubble",  OP_ADD, 32'h00000000, 32'h0, 2'd0, 32'h0, 4'b0000, 5'd9, 32'hDEAD5678);

      // HI/LO forward then hold.
      wb_hilo_wen = 1'b1;
      wb_hilo     = 64'h0123456789ABCDEF;
      #1;
      push(64'h0123456789ABCDEF); check("hilo_fwd", hilo_o);
      step();
      wb_hilo_wen = 1'b0;
      wb_hilo     = 64'hFFFF0000FFFF0000;
      #1;
      push(64'h0123456789ABCDEF); check("hilo_hold", hilo_o);
      step();
      push(64'h0123456789ABCDEF); check("hilo_hold2", hilo_o);

      // LL sets LLbit.
      wb_llb_wen = 1'b1;
      wb_llbit   = 1'b1;
      #1;
      push(64'd1); check("ll_fwd", {63'b0, llbit_o});
      wr_check("ll_r11", OP_LL, 32'h0, 32'h0, 2'd0, 32'h00000055, 4'hF, 5'd11, 32'h00000055);
      push(64'd1); check("ll_stored", {63'b0, llbit_o});

      // SC succeeding writes 1 to rt.
      wb_llbit = 1'b1;
      wr_check("sc_r12", OP_SC, 32'hFFFFFFFF, 32'h0, 2'd0, 32'h0, 4'hF, 5'd12, 32'h00000001);

      // SC with llb_clr and llb_wen: rt takes wb_llbit, LLbit clears.
      wb_llb_wen = 1'b1;
      llb_clr    = 1'b1;
      wb_llbit   = 1'b1;
      #1;
      push(64'd0); check("clr_fwd", {63'b0, llbit_o});
      wr_check("sc_clr_r13", OP_SC, 32'h0, 32'h0, 2'd0, 32'h0, 4'hF, 5'd13, 32'h00000001);
      push(64'd0); check("clr_stored", {63'b0, llbit_o});

      // Set LLbit again, then reset mid-stream with writes presented.
      wb_llb_wen = 1'b1;
      wb_llbit   = 1'b1;
      step();
      bubble();
      #1;
      push(64'd1); check("ll_again", {63'b0, llbit_o});
      rst         = 1'b1;
      wb_aluop    = OP_ADD;
      wb_alures   = 32'h00000077;
      wb_wreg     = 4'hF;
      wb_wraddr   = 5'd14;
      wb_hilo_wen = 1'b1;
      wb_hilo     = 64'hAAAA5555AAAA5555;
      r1_addr     = 5'd14;
      r2_addr     = 5'd9;
      #1;
      push(64'h77); check("rst_fwd_r14", {32'b0, r1_data});
      push(64'hAAAA5555AAAA5555); check("rst_fwd_hilo", hilo_o);
      step();
      rst = 1'b0;
      bubble();
      #1;
      push(64'd0); check("post_rst_r14", {32'b0, r1_data});
      push(64'd0); check("post_rst_r9", {32'b0, r2_data});
      push(64'd0); check("post_rst_hilo", hilo_o);
      push(64'd0); check("post_rst_llbit", {63'b0, llbit_o});

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
